// File: rtl/pulse_generator_pkg.sv
// pulse_generator_pkg: shared state encoding and width helper for the pulse generator
package pulse_generator_pkg;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PULSE = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;
    localparam logic [1:0] GAP   = 2'd3;
    function automatic int pg_width(input int max_len);
        return $clog2(max_len + 1);
    endfunction
endpackage

// File: rtl/load_down_counter.sv
// load_down_counter: loadable down-counter that saturates at zero, with an is_one flag
module load_down_counter #(
    parameter int W = 11
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         load,
    input  logic         enable,
    input  logic [W-1:0] value,
    output logic [W-1:0] count,
    output logic         is_one
);
    assign is_one = count == W'(1);
    // load has priority over counting; the count never goes below zero
    always_ff @(posedge clock_i) begin
        if (reset_i) count <= '0;
        else if (load) count <= value;
        else if (enable && count != '0) count <= count - W'(1);
    end
endmodule

// File: rtl/pulse_generator.sv
// pulse_generator: emits one pulse of a requested length; PULSE_GENERATOR_REPEAT_EN adds square-wave repeat mode
module pulse_generator
    import pulse_generator_pkg::*;
#(
    parameter int MAX_PULSE_LENGTH = 2000,
    localparam int W = pg_width(MAX_PULSE_LENGTH)
) (
    input  logic         clock_i,
    input  logic         reset_i,
    input  logic         start_i,
    input  logic [W-1:0] length_i,
    input  logic         abort_i,
`ifdef PULSE_GENERATOR_REPEAT_EN
    input  logic         repeat_i,
`endif
    output logic         ready_o,
    output logic         pulse_o,
    output logic         busy_o,
    output logic         finished_o,
    output logic [W-1:0] remaining_o
);
    logic [1:0]   state, next_state;
    logic [W-1:0] len_c, count, load_value;
    logic         accept, active, phase_end, is_one, load, rep;
    assign ready_o   = state == IDLE || state == DONE;
    assign accept    = start_i & ready_o & ~abort_i;
    assign len_c     = length_i > W'(MAX_PULSE_LENGTH) ? W'(MAX_PULSE_LENGTH) : length_i;
    assign active    = state == PULSE || state == GAP;
    assign phase_end = active & is_one;
    assign remaining_o = state == PULSE ? count : '0;
`ifdef PULSE_GENERATOR_REPEAT_EN
    logic         repeat_q;
    logic [W-1:0] period_q;
    assign rep        = repeat_q;
    assign load_value = abort_i ? '0 : accept ? len_c : period_q;
    // remember the mode and half-period so each phase can reload the counter
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            repeat_q <= 1'b0;
            period_q <= '0;
        end else if (accept) begin
            repeat_q <= repeat_i;
            period_q <= len_c;
        end
    end
`else
    assign rep        = 1'b0;
    assign load_value = abort_i ? '0 : len_c;
`endif
    assign load = abort_i | accept | (phase_end & rep);
    load_down_counter #(.W(W)) u_counter (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .load   (load),
        .enable (active),
        .value  (load_value),
        .count  (count),
        .is_one (is_one)
    );
    // abort wins over everything but reset; phases end when the counter shows its last cycle
    always_comb begin
        next_state = abort_i ? IDLE :
                     accept ? (len_c == '0 ? DONE : PULSE) :
                     phase_end ? (state == GAP ? PULSE : rep ? GAP : DONE) :
                     state;
    end
    // state and outputs register together so the pulse starts the cycle after accept
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state      <= IDLE;
            pulse_o    <= 1'b0;
            busy_o     <= 1'b0;
            finished_o <= 1'b0;
        end else begin
            state      <= next_state;
            pulse_o    <= next_state == PULSE;
            busy_o     <= next_state == PULSE || next_state == GAP;
            finished_o <= next_state == DONE;
        end
    end
endmodule

// File: tb/tb_pulse_generator.sv
// tb_pulse_generator: directed self-checking bench for pulse_generator
module tb_pulse_generator;
    localparam int W = 11;
    logic         clock = 1'b0;
    logic         reset_i = 1'b1;
    logic         start_i = 1'b0;
    logic [W-1:0] length_i = '0;
    logic         abort_i = 1'b0;
`ifdef PULSE_GENERATOR_REPEAT_EN
    logic         repeat_i = 1'b0;
`endif
    logic         ready_o, pulse_o, busy_o, finished_o;
    logic [W-1:0] remaining_o;
    int           n_cmp = 0;
    int           n_bad = 0;
    int           width;

    pulse_generator #(.MAX_PULSE_LENGTH(2000)) dut (
        .clock_i    (clock),
        .reset_i    (reset_i),
        .start_i    (start_i),
        .length_i   (length_i),
        .abort_i    (abort_i),
`ifdef PULSE_GENERATOR_REPEAT_EN
        .repeat_i   (repeat_i),
`endif
        .ready_o    (ready_o),
        .pulse_o    (pulse_o),
        .busy_o     (busy_o),
        .finished_o (finished_o),
        .remaining_o(remaining_o)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic measure(input int budget);
        width = 0;
        while (pulse_o === 1'b1 && width < budget) begin
            cycle();
            width++;
        end
    endtask

    initial begin
        start_i  = 1'b1;
        length_i = 11'd5;
        repeat (3) cycle();
        reset_i = 1'b0;
        start_i = 1'b0;
        check("rst_pulse", 32'(pulse_o), 32'd0);
        check("rst_fin", 32'(finished_o), 32'd0);
        check("rst_rem", 32'(remaining_o), 32'd0);
        check("rst_ready", 32'(ready_o), 32'd1);
        check("rst_busy", 32'(busy_o), 32'd0);

        start_i  = 1'b1;
        length_i = 11'd5;
        cycle();
        start_i = 1'b0;
        for (int i = 0; i < 5; i++) begin
            check("l5_pulse", 32'(pulse_o), 32'd1);
            check("l5_rem", 32'(remaining_o), 32'(5 - i));
            check("l5_ready", 32'(ready_o), 32'd0);
            check("l5_busy", 32'(busy_o), 32'd1);
            cycle();
        end
        check("l5_end_pulse", 32'(pulse_o), 32'd0);
        check("l5_end_fin", 32'(finished_o), 32'd1);
        check("l5_end_rem", 32'(remaining_o), 32'd0);
        check("l5_end_ready", 32'(ready_o), 32'd1);
        cycle();
        check("l5_fin_hold", 32'(finished_o), 32'd1);

        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check("abort_done_fin", 32'(finished_o), 32'd0);
        start_i  = 1'b1;
        length_i = 11'd0;
        cycle();
        start_i = 1'b0;
        check("l0_pulse", 32'(pulse_o), 32'd0);
        check("l0_fin", 32'(finished_o), 32'd1);
        check("l0_busy", 32'(busy_o), 32'd0);

        start_i  = 1'b1;
        length_i = 11'd2047;
        cycle();
        start_i = 1'b0;
        check("clamp_rem", 32'(remaining_o), 32'd2000);
        measure(3000);
        check("clamp_width", 32'(width), 32'd2000);
        check("clamp_fin", 32'(finished_o), 32'd1);

        start_i  = 1'b1;
        length_i = 11'd10;
        cycle();
        repeat (3) cycle();
        check("hold_pulse", 32'(pulse_o), 32'd1);
        check("hold_rem", 32'(remaining_o), 32'd7);
        abort_i = 1'b1;
        cycle();
        check("ab_pulse", 32'(pulse_o), 32'd0);
        check("ab_fin", 32'(finished_o), 32'd0);
        check("ab_rem", 32'(remaining_o), 32'd0);
        check("ab_ready", 32'(ready_o), 32'd1);
        check("ab_busy", 32'(busy_o), 32'd0);
        cycle();
        check("ab_hold_pulse", 32'(pulse_o), 32'd0);
        abort_i = 1'b0;
        cycle();
        start_i = 1'b0;
        check("reacc_pulse", 32'(pulse_o), 32'd1);
        check("reacc_rem", 32'(remaining_o), 32'd10);
        measure(50);
        check("reacc_width", 32'(width), 32'd10);

        start_i  = 1'b1;
        length_i = 11'd3;
        cycle();
        start_i = 1'b0;
        measure(50);
        check("b2b_w3", 32'(width), 32'd3);
        check("b2b_gap", 32'(pulse_o), 32'd0);
        check("b2b_fin3", 32'(finished_o), 32'd1);
        start_i  = 1'b1;
        length_i = 11'd1;
        cycle();
        start_i = 1'b0;
        check("b2b_clr", 32'(finished_o), 32'd0);
        check("b2b_rem1", 32'(remaining_o), 32'd1);
        measure(50);
        check("b2b_w1", 32'(width), 32'd1);
        check("b2b_fin1", 32'(finished_o), 32'd1);

`ifdef PULSE_GENERATOR_REPEAT_EN
        start_i  = 1'b1;
        repeat_i = 1'b1;
        length_i = 11'd4;
        cycle();
        start_i  = 1'b0;
        repeat_i = 1'b0;
        for (int p = 0; p < 3; p++) begin
            for (int i = 0; i < 8; i++) begin
                check("rep_pulse", 32'(pulse_o), 32'(i < 4));
                check("rep_fin", 32'(finished_o), 32'd0);
                check("rep_ready", 32'(ready_o), 32'd0);
                cycle();
            end
        end
        repeat (4) cycle();
        check("rep_gap", 32'(pulse_o), 32'd0);
        abort_i = 1'b1;
        cycle();
        abort_i = 1'b0;
        check("rep_ab_pulse", 32'(pulse_o), 32'd0);
        check("rep_ab_busy", 32'(busy_o), 32'd0);
        check("rep_ab_ready", 32'(ready_o), 32'd1);
        cycle();
        check("rep_ab_stay", 32'(pulse_o), 32'd0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
